// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-port scheduler in front of the pipelined ALU.
package alu_sched_pkg;

  localparam int ALU_LAT = 2;
  localparam int RSP_LAT = 3;
  localparam int NPORT   = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLTU = 4'b0011,
    OP_SLT  = 4'b0010,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } alu_op_e;

  typedef struct packed {
    logic v;
    logic z;
    logic n;
    logic c;
    logic cout;
  } flags_t;

  typedef struct packed {
    logic                       valid;
    logic [$clog2(NPORT)-1:0]   port;
    logic                       err;
  } tag_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLTU, OP_SLT,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers which port was granted last.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_port1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = last_port1;
        gnt1 = ~last_port1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Pointer only moves on a grant, so an idle cycle never changes fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_port1 <= 1'b1;
    end else if (gnt0) begin
      last_port1 <= 1'b0;
    end else if (gnt1) begin
      last_port1 <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end sharing one 2-cycle ALU between two requesters,
// with a tag pipe that routes each registered result back to its port.
module alu_rr_scheduler
  import alu_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic [4:0]  alu_flags,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_res,
  output logic [4:0]  rsp0_flags,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_res,
  output logic [4:0]  rsp1_flags,
  output logic        rsp1_err,
  output logic        busy,
  output logic [15:0] acc0_cnt,
  output logic [15:0] acc1_cnt,
  output logic [7:0]  err_cnt
);

  logic        gnt0, gnt1, accept, sel_port, sel_legal;
  logic [31:0] sel_a, sel_b;
  logic [3:0]  sel_op;
  tag_t        tag_pipe [ALU_LAT];
  tag_t        out_tag;
  logic [31:0] rsp_res_next;
  flags_t      rsp_flags_next;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel_port   = gnt1;
  assign sel_a      = gnt1 ? req1_a  : req0_a;
  assign sel_b      = gnt1 ? req1_b  : req0_b;
  assign sel_op     = gnt1 ? req1_op : req0_op;
  assign sel_legal  = is_legal_op(sel_op);

  // Illegal opcodes are accepted but never reach the ALU.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (accept && sel_legal) begin
      alu_a  = sel_a;
      alu_b  = sel_b;
      alu_op = sel_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ALU_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: accept, port: sel_port, err: accept & ~sel_legal};
      for (int i = 1; i < ALU_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign out_tag        = tag_pipe[ALU_LAT-1];
  assign rsp_res_next   = out_tag.err ? '0 : alu_res;
  assign rsp_flags_next = out_tag.err ? '0 : flags_t'(alu_flags);

  // Only the addressed port's payload moves; the other keeps its last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_res   <= '0;
      rsp0_flags <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_res   <= '0;
      rsp1_flags <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= out_tag.valid && (out_tag.port == 1'b0);
      rsp1_valid <= out_tag.valid && (out_tag.port == 1'b1);
      if (out_tag.valid && (out_tag.port == 1'b0)) begin
        rsp0_res   <= rsp_res_next;
        rsp0_flags <= rsp_flags_next;
        rsp0_err   <= out_tag.err;
      end
      if (out_tag.valid && (out_tag.port == 1'b1)) begin
        rsp1_res   <= rsp_res_next;
        rsp1_flags <= rsp_flags_next;
        rsp1_err   <= out_tag.err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc0_cnt <= '0;
      acc1_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (gnt0) acc0_cnt <= acc0_cnt + 16'd1;
      if (gnt1) acc1_cnt <= acc1_cnt + 16'd1;
      if (accept && !sel_legal && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign busy = tag_pipe[0].valid | tag_pipe[1].valid | rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: ALU stub, request driver, and a
// transaction-level model compared against the DUT every cycle.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic [4:0]  alu_flags;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_res, rsp1_res;
  logic [4:0]  rsp0_flags, rsp1_flags;
  logic        busy;
  logic [15:0] acc0_cnt, acc1_cnt;
  logic [7:0]  err_cnt;

  alu_rr_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .rsp0_valid(rsp0_valid), .rsp0_res(rsp0_res), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_res(rsp1_res), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
    .busy(busy), .acc0_cnt(acc0_cnt), .acc1_cnt(acc1_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour, returns {res, v, z, n, c, cout}.
  function automatic logic [36:0] calc(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        v, c;
    w = '0; r = '0; v = 1'b0; c = 1'b0;
    case (op)
      4'b0000: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b1000: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0001: r = a << b[4:0];
      4'b0011: r = (a < b) ? 32'd1 : 32'd0;
      4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $unsigned($signed(a) >>> b[4:0]);
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: return '0;
    endcase
    return {r, v, (r == 32'd0), r[31], c, c};
  endfunction

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b1000, 4'b0001, 4'b0011, 4'b0010, 4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  endfunction

  // Two-register ALU stub standing in for the shared ALU.
  logic [31:0] s_a = '0, s_b = '0;
  logic [3:0]  s_op = '0;
  logic [36:0] s_out = '0;
  always @(posedge clk) begin
    s_a   <= alu_a;
    s_b   <= alu_b;
    s_op  <= alu_op;
    s_out <= calc(s_a, s_b, s_op);
  end
  assign alu_res   = s_out[36:5];
  assign alu_flags = s_out[4:0];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } req_t;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] res;
    logic [4:0]  flags;
    logic        err;
  } exp_t;

  req_t q0[$], q1[$];
  exp_t mq[$];
  int   grant_log[$], rsp_log[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, last_port = 1, m_acc0 = 0, m_acc1 = 0, m_err = 0;
  int   dut_rsp_pulses = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
  logic [31:0] held_res [2];
  logic [4:0]  held_flags [2];
  logic        held_err [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    if (port == 0) q0.push_back(r);
    else           q1.push_back(r);
  endtask

  // Requesters hold a/b/op until their handshake, then present the next item.
  initial begin : driver
    logic hs0, hs1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    forever begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) void'(q0.pop_front());
      if (hs1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1'b1; req0_a = q0[0].a; req0_b = q0[0].b; req0_op = q0[0].op;
      end else begin
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      end
      if (q1.size() > 0) begin
        req1_valid = 1'b1; req1_a = q1[0].a; req1_b = q1[0].b; req1_op = q1[0].op;
      end else begin
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      end
    end
  end

  // Transaction model: queue of expected responses with due cycles.
  initial begin : compare
    int          rp, g;
    exp_t        e;
    logic [31:0] ea, eb, ga, gb;
    logic [3:0]  eo, go;
    logic [36:0] r;
    for (int p = 0; p < 2; p++) begin held_res[p] = '0; held_flags[p] = '0; held_err[p] = 1'b0; end
    @(posedge clk);
    forever begin
      @(negedge clk);
      rp = -1;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        e = mq.pop_front();
        rp = e.port;
        held_res[rp] = e.res; held_flags[rp] = e.flags; held_err[rp] = e.err;
      end
      checkOutput("rsp0_valid", rsp0_valid, rp == 0);
      checkOutput("rsp1_valid", rsp1_valid, rp == 1);
      checkOutput("rsp0_res", rsp0_res, held_res[0]);
      checkOutput("rsp0_flags", rsp0_flags, held_flags[0]);
      checkOutput("rsp0_err", rsp0_err, held_err[0]);
      checkOutput("rsp1_res", rsp1_res, held_res[1]);
      checkOutput("rsp1_flags", rsp1_flags, held_flags[1]);
      checkOutput("rsp1_err", rsp1_err, held_err[1]);
      checkOutput("busy", busy, (mq.size() > 0) || (rp >= 0));
      checkOutput("acc0_cnt", acc0_cnt, m_acc0);
      checkOutput("acc1_cnt", acc1_cnt, m_acc1);
      checkOutput("err_cnt", err_cnt, m_err);

      g = -1;
      if (!rst) begin
        if (req0_valid && req1_valid) g = 1 - last_port;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end
      checkOutput("req0_ready", req0_ready, g == 0);
      checkOutput("req1_ready", req1_ready, g == 1);
      ga = (g == 1) ? req1_a : req0_a;
      gb = (g == 1) ? req1_b : req0_b;
      go = (g == 1) ? req1_op : req0_op;
      ea = '0; eb = '0; eo = '0;
      if (g >= 0 && legal(go)) begin ea = ga; eb = gb; eo = go; end
      checkOutput("alu_a", alu_a, ea);
      checkOutput("alu_b", alu_b, eb);
      checkOutput("alu_op", alu_op, eo);

      if (req0_valid && req0_ready) begin grant_log.push_back(0); last_acc_cyc = cyc; end
      if (req1_valid && req1_ready) begin grant_log.push_back(1); last_acc_cyc = cyc; end
      if (rsp0_valid) begin rsp_log.push_back(0); dut_rsp_pulses++; last_rsp_cyc = cyc; end
      if (rsp1_valid) begin rsp_log.push_back(1); dut_rsp_pulses++; last_rsp_cyc = cyc; end

      if (rst) begin
        mq.delete();
        m_acc0 = 0; m_acc1 = 0; m_err = 0; last_port = 1;
        for (int p = 0; p < 2; p++) begin held_res[p] = '0; held_flags[p] = '0; held_err[p] = 1'b0; end
      end else if (g >= 0) begin
        e.due = cyc + RSP_LAT;
        e.port = g;
        if (legal(go)) begin
          r = calc(ga, gb, go);
          e.res = r[36:5]; e.flags = r[4:0]; e.err = 1'b0;
        end else begin
          e.res = '0; e.flags = '0; e.err = 1'b1;
          if (m_err < 255) m_err++;
        end
        mq.push_back(e);
        if (g == 0) m_acc0 = (m_acc0 + 1) % 65536;
        else        m_acc1 = (m_acc1 + 1) % 65536;
        last_port = g;
      end
      cyc++;
    end
  end

  task automatic waitIdle(input string name, input int limit);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mq.size() > 0) && n < limit) begin
      @(posedge clk); #2; n++;
    end
    checkOutput({name, "_timeout"}, n < limit, 1'b1);
  endtask

  task automatic waitDrained(input string name, input int limit);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < limit) begin
      @(posedge clk); #2; n++;
    end
    checkOutput({name, "_timeout"}, n < limit, 1'b1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin : main
    int p;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("pin_add", calc(32'd5, 32'd7, 4'b0000), {32'd12, 5'b00000});
    checkOutput("pin_sub", calc(32'd1, 32'd2, 4'b1000), {32'hFFFF_FFFF, 5'b00100});
    checkOutput("pin_ovf", calc(32'h7FFF_FFFF, 32'd1, 4'b0000), {32'h8000_0000, 5'b10100});
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_rsp0_valid", rsp0_valid, 1'b0);
    checkOutput("rst_acc0", acc0_cnt, 16'd0);
    rst = 1'b0;

    $display("[TB] single add");
    applyStimulus(0, 32'd5, 32'd7, 4'b0000);
    waitIdle("add", 20);
    checkOutput("add_res", rsp0_res, 32'd12);
    checkOutput("add_z", rsp0_flags[3], 1'b0);
    checkOutput("add_n", rsp0_flags[2], 1'b0);
    checkOutput("add_err", rsp0_err, 1'b0);
    checkOutput("add_latency", last_rsp_cyc - last_acc_cyc, 3);
    checkOutput("add_acc0", acc0_cnt, 16'd1);

    $display("[TB] tie");
    doReset();
    grant_log.delete();
    rsp_log.delete();
    applyStimulus(0, 32'd10, 32'd3, 4'b1000);
    applyStimulus(1, 32'h0000_FF00, 32'h0000_0FF0, 4'b0100);
    applyStimulus(0, 32'd1, 32'd4, 4'b0001);
    applyStimulus(1, 32'h0000_00F0, 32'h0000_000F, 4'b0110);
    waitIdle("tie", 30);
    checkOutput("tie_ngrants", grant_log.size(), 4);
    checkOutput("tie_nrsps", rsp_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) checkOutput("tie_grant", grant_log[i], i % 2);
    for (int i = 0; i < 4 && i < rsp_log.size(); i++) checkOutput("tie_rsp_port", rsp_log[i], i % 2);
    checkOutput("tie_acc0", acc0_cnt, 16'd2);
    checkOutput("tie_acc1", acc1_cnt, 16'd2);
    checkOutput("tie_rsp0_res", rsp0_res, 32'd16);
    checkOutput("tie_rsp1_res", rsp1_res, 32'h0000_00FF);

    $display("[TB] mixed ops");
    applyStimulus(0, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    applyStimulus(1, 32'hFFFF_FFFF, 32'd1, 4'b0011);
    applyStimulus(0, 32'h8000_0000, 32'd4, 4'b1101);
    applyStimulus(1, 32'h8000_0000, 32'd4, 4'b0101);
    applyStimulus(0, 32'h7FFF_FFFF, 32'd1, 4'b0000);
    applyStimulus(1, 32'd3, 32'd3, 4'b1000);
    applyStimulus(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111);
    waitIdle("mix", 40);
    checkOutput("mix_rsp0_res", rsp0_res, 32'hF000_F000);
    checkOutput("mix_rsp1_z", rsp1_flags[3], 1'b1);

    $display("[TB] illegal op");
    doReset();
    applyStimulus(1, 32'd9, 32'd9, 4'b0000);
    applyStimulus(1, 32'd9, 32'd9, 4'b1111);
    waitIdle("ill", 20);
    checkOutput("ill_err", rsp1_err, 1'b1);
    checkOutput("ill_res", rsp1_res, 32'd0);
    checkOutput("ill_flags", rsp1_flags, 5'd0);
    checkOutput("ill_err_cnt", err_cnt, 8'd1);
    checkOutput("ill_acc1", acc1_cnt, 16'd2);

    $display("[TB] reset mid-flight");
    doReset();
    p = dut_rsp_pulses;
    applyStimulus(0, 32'd1, 32'd1, 4'b0000);
    waitDrained("mid", 10);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    checkOutput("mid_no_rsp", dut_rsp_pulses - p, 0);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_acc0", acc0_cnt, 16'd0);
    checkOutput("mid_err_cnt", err_cnt, 8'd0);

    $display("[TB] counter wrap and saturation");
    doReset();
    for (int i = 0; i < 300; i++) applyStimulus(0, i, i, 4'b1111);
    waitIdle("sat", 400);
    checkOutput("sat_err_cnt", err_cnt, 8'hFF);
    checkOutput("sat_acc0", acc0_cnt, 16'd300);
    for (int i = 0; i < 65235; i++) applyStimulus(0, i, 32'd1, 4'b1111);
    waitIdle("wrap_fill", 70000);
    checkOutput("wrap_full", acc0_cnt, 16'hFFFF);
    applyStimulus(0, 32'd2, 32'd3, 4'b0000);
    waitIdle("wrap", 20);
    checkOutput("wrap_zero", acc0_cnt, 16'h0000);
    checkOutput("wrap_err_cnt", err_cnt, 8'hFF);
    checkOutput("wrap_res", rsp0_res, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
